// File: rtl/sand_sweep.sv
// Frame sequencer: walks the framebuffer one 16-cell word at a time, feeding
// region (row r) and floor (row r+1) to sand_update and writing both results back.
module sand_sweep #(
   parameter int COLS = 40,
   parameter int ROWS = 480,
   parameter int AW   = 15
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic                    spout_en,
   input  logic [$clog2(COLS)-1:0] spout_col,
   output logic                    busy,
   output logic                    done,
   output logic [15:0]             frame_count,
   output logic [AW-1:0]           mem_addr,
   output logic                    mem_rd,
   input  logic [31:0]             mem_rdata,
   output logic                    mem_wr,
   output logic [31:0]             mem_wdata,
   output logic [31:0]             region,
   output logic [31:0]             floor,
   output logic                    screenbegin,
   output logic                    screenend,
   output logic                    screenbottom,
   output logic                    spout,
   input  logic [31:0]             new_region,
   input  logic [31:0]             new_floor
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);
   localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
   localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
   localparam logic [AW-1:0] COLS_A   = AW'(COLS);

   typedef enum logic [2:0] {IDLE, RD_R, RD_F, CAP, WR_R, WR_F, DONE} state_t;

   state_t        state_q, state_d;
   logic [RW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          spout_en_q, spout_en_d;
   logic [31:0]   region_q, region_d;
   logic [31:0]   floor_q, floor_d;
   logic [15:0]   frame_count_q, frame_count_d;

   state_t        adv_state_s;
   logic [RW-1:0] adv_row_s;
   logic [CW-1:0] adv_col_s;
   logic          bottom_s;
   logic          last_word_s;
   logic          word_s;
   logic [AW-1:0] region_addr_s;
   logic [AW-1:0] floor_addr_s;

   assign bottom_s      = (row_q == LAST_ROW);
   assign last_word_s   = bottom_s && (col_q == LAST_COL);
   assign word_s        = (state_q != IDLE) && (state_q != DONE);
   assign region_addr_s = AW'(row_q) * COLS_A + AW'(col_q);
   assign floor_addr_s  = region_addr_s + COLS_A;

   // counter step taken after the final write of a word
   always_comb begin
      adv_state_s = RD_R;
      adv_row_s   = row_q;
      adv_col_s   = col_q;
      if (last_word_s) begin
         adv_state_s = DONE;
         adv_row_s   = '0;
         adv_col_s   = '0;
      end else if (col_q != LAST_COL) begin
         adv_col_s = col_q + CW'(1);
      end else begin
         adv_col_s = '0;
         adv_row_s = row_q + RW'(1);
      end
   end

   // sequencer next-state
   always_comb begin
      state_d       = state_q;
      row_d         = row_q;
      col_d         = col_q;
      spout_en_d    = spout_en_q;
      region_d      = region_q;
      floor_d       = floor_q;
      frame_count_d = frame_count_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               spout_en_d = spout_en;
               state_d    = RD_R;
            end else begin
               state_d = IDLE;
            end
         end
         RD_R: state_d = RD_F;
         RD_F: begin
            region_d = mem_rdata;
            state_d  = CAP;
         end
         CAP: begin
            // the bottom row's floor is a virtual wall row that is never read
            floor_d = bottom_s ? 32'h0000_0000 : mem_rdata;
            state_d = WR_R;
         end
         WR_R: begin
            if (bottom_s) begin
               state_d = adv_state_s;
               row_d   = adv_row_s;
               col_d   = adv_col_s;
            end else begin
               state_d = WR_F;
            end
         end
         WR_F: begin
            state_d = adv_state_s;
            row_d   = adv_row_s;
            col_d   = adv_col_s;
         end
         DONE: begin
            frame_count_d = frame_count_q + 16'd1;
            row_d         = '0;
            col_d         = '0;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // state, counters and data registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         row_q         <= '0;
         col_q         <= '0;
         spout_en_q    <= 1'b0;
         region_q      <= 32'h0000_0000;
         floor_q       <= 32'h0000_0000;
         frame_count_q <= 16'h0000;
      end else begin
         state_q       <= state_d;
         row_q         <= row_d;
         col_q         <= col_d;
         spout_en_q    <= spout_en_d;
         region_q      <= region_d;
         floor_q       <= floor_d;
         frame_count_q <= frame_count_d;
      end
   end

   // RAM strobes decoded from the state register only
   always_comb begin
      mem_rd    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = 32'h0000_0000;
      case (state_q)
         RD_R: begin
            mem_rd   = 1'b1;
            mem_addr = region_addr_s;
         end
         RD_F: begin
            if (!bottom_s) begin
               mem_rd   = 1'b1;
               mem_addr = floor_addr_s;
            end else begin
               mem_rd = 1'b0;
            end
         end
         WR_R: begin
            mem_wr    = 1'b1;
            mem_addr  = region_addr_s;
            mem_wdata = new_region;
         end
         WR_F: begin
            mem_wr    = 1'b1;
            mem_addr  = floor_addr_s;
            mem_wdata = new_floor;
         end
         default: mem_rd = 1'b0;
      endcase
   end

   assign busy         = (state_q != IDLE);
   assign done         = (state_q == DONE);
   assign frame_count  = frame_count_q;
   assign region       = region_q;
   assign floor        = floor_q;
   assign screenbegin  = word_s && (col_q == '0);
   assign screenend    = word_s && (col_q == LAST_COL);
   assign screenbottom = word_s && bottom_s;
   assign spout        = word_s && spout_en_q && (row_q == '0) && (col_q == spout_col);

endmodule

// File: tb/tb_sand_sweep.sv
// Directed bench for sand_sweep on a 2x3-word frame with a behavioural RAM
// and a small sand_update model (SAND=01, freshly fallen SAND_AM=11).
module tb_sand_sweep;
   localparam int COLS = 2;
   localparam int ROWS = 3;
   localparam int AW   = 4;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic        spout_en;
   logic [0:0]  spout_col;
   logic        busy, done;
   logic [15:0] frame_count;
   logic [AW-1:0] mem_addr;
   logic        mem_rd, mem_wr;
   logic [31:0] mem_rdata, mem_wdata;
   logic [31:0] region, floor, new_region, new_floor;
   logic        screenbegin, screenend, screenbottom, spout;

   logic [31:0]   ram [0:15];
   logic          tb_we = 1'b0;
   logic [AW-1:0] tb_addr = '0;
   logic [31:0]   tb_data = 32'h0;

   int checks = 0;
   int errors = 0;
   int exp_frames = 0;
   int rd_q[$];
   int wr_q[$];
   int busy_cnt, done_cyc, n_done, n_wr, both_hi, spout_first, spout_cnt;
   logic        post_busy;
   logic [15:0] post_fc;

   sand_sweep #(.COLS(COLS), .ROWS(ROWS), .AW(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .spout_en(spout_en),
      .spout_col(spout_col), .busy(busy), .done(done), .frame_count(frame_count),
      .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .region(region), .floor(floor),
      .screenbegin(screenbegin), .screenend(screenend), .screenbottom(screenbottom),
      .spout(spout), .new_region(new_region), .new_floor(new_floor)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_wr) ram[mem_addr] <= mem_wdata;
      else if (tb_we) ram[tb_addr] <= tb_data;
      if (mem_rd) mem_rdata <= ram[mem_addr];
   end

   function automatic logic [63:0] sand_model(input logic [31:0] r_in, input logic [31:0] f_in,
                                              input logic sp, input logic bot);
      logic [31:0] r, f;
      r = sp ? (r_in | 32'h0000_5555) : r_in;
      f = f_in;
      for (int i = 0; i < 16; i++) begin
         if (r[2*i +: 2] == 2'b11) begin
            r[2*i +: 2] = 2'b01;
         end else if (r[2*i +: 2] == 2'b01 && !bot && f[2*i +: 2] == 2'b00) begin
            r[2*i +: 2] = 2'b00;
            f[2*i +: 2] = 2'b11;
         end
      end
      return {r, f};
   endfunction

   assign {new_region, new_floor} = sand_model(region, floor, spout, screenbottom);

   task automatic load_ram(input logic [31:0] w0, w1, w2, w3, w4, w5);
      logic [31:0] w [6];
      w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3; w[4] = w4; w[5] = w5;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tb_we = 1'b1; tb_addr = AW'(i); tb_data = w[i];
      end
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   // start in cycle 0, record activity per cycle until one cycle past done
   task automatic sweep(input int restart_cyc, input logic sp_en);
      rd_q.delete(); wr_q.delete();
      busy_cnt = 0; done_cyc = -1; n_done = 0; n_wr = 0; both_hi = 0;
      spout_first = -1; spout_cnt = 0; post_busy = 1'b1; post_fc = 16'hxxxx;
      @(negedge clk);
      start = 1'b1; spout_en = sp_en;
      for (int c = 1; c <= 200; c++) begin
         @(negedge clk);
         start = (c == restart_cyc) ? 1'b1 : 1'b0;
         spout_en = 1'b0;
         if (busy && c <= 28) busy_cnt++;
         if (mem_rd) rd_q.push_back(int'(mem_addr));
         if (mem_wr) begin n_wr++; wr_q.push_back(int'(mem_addr)); end
         if (mem_rd && mem_wr) both_hi++;
         if (spout) begin spout_cnt++; if (spout_first < 0) spout_first = c; end
         if (done) begin n_done++; done_cyc = c; end
         if (done_cyc > 0 && c == done_cyc + 1) begin
            post_busy = busy; post_fc = frame_count;
            break;
         end
      end
      start = 1'b0;
      if (done_cyc > 0) exp_frames++;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; spout_en = 1'b0; spout_col = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_rd, mem_wr, screenbegin, screenend, screenbottom, spout} !== 8'h00) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000000",
                  {busy, done, mem_rd, mem_wr, screenbegin, screenend, screenbottom, spout});
      end
      checks++;
      if ({mem_addr, mem_wdata, region, floor, frame_count} !== '0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wdata=%h region=%h floor=%h fc=%h expected all 0",
                  mem_addr, mem_wdata, region, floor, frame_count);
      end
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset_mid_sweep;
      int n_acc;
      load_ram(32'h0000_0400, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      @(negedge clk);
      start = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         start = 1'b0;
      end
      checks++;
      if (region !== 32'h0000_0400 || mem_rd !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: region=%h rd=%b expected 00000400 1", region, mem_rd);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_rd, mem_wr, screenbegin, screenend, screenbottom, spout} !== 8'h00 ||
          {mem_addr, mem_wdata, region, floor, frame_count} !== '0) begin
         errors++;
         $display("FAIL midsweep_reset: busy=%b rd=%b addr=%h region=%h flags=%b expected all 0",
                  busy, mem_rd, mem_addr, region, {screenbegin, screenend, screenbottom, spout});
      end
      @(negedge clk);
      reset_n = 1'b1;
      exp_frames = 0;
      n_acc = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_wr || mem_rd || busy) n_acc++;
      end
      checks++;
      if (n_acc !== 0) begin
         errors++;
         $display("FAIL post_reset_idle: got %0d active cycles expected 0", n_acc);
      end
   endtask

   task automatic test_cycle_count;
      load_ram(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      sweep(-1, 1'b0);
      checks++;
      if (busy_cnt !== 28) begin
         errors++; $display("FAIL busy_cycles: got %0d expected 28", busy_cnt);
      end
      checks++;
      if (n_wr !== 10) begin
         errors++; $display("FAIL write_count: got %0d expected 10", n_wr);
      end
      checks++;
      if (done_cyc !== 29 || n_done !== 1) begin
         errors++; $display("FAIL done_cycle: got cycle %0d count %0d expected 29 1", done_cyc, n_done);
      end
      checks++;
      if (post_fc !== 16'd1 || post_busy !== 1'b0) begin
         errors++; $display("FAIL frame_count: got fc=%0d busy=%b expected 1 0", post_fc, post_busy);
      end
      checks++;
      if (both_hi !== 0) begin
         errors++; $display("FAIL rd_wr_overlap: got %0d expected 0", both_hi);
      end
      checks++;
      if ((ram[0] | ram[1] | ram[2] | ram[3] | ram[4] | ram[5]) !== 32'h0) begin
         errors++; $display("FAIL ram_unchanged: got or=%h expected 0",
                            ram[0] | ram[1] | ram[2] | ram[3] | ram[4] | ram[5]);
      end
   endtask

   task automatic test_address_seq;
      int exp_seq [10];
      exp_seq = '{0, 2, 1, 3, 2, 4, 3, 5, 4, 5};
      load_ram(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      sweep(-1, 1'b0);
      checks++;
      if (rd_q.size() !== 10 || wr_q.size() !== 10) begin
         errors++; $display("FAIL addr_len: got rd=%0d wr=%0d expected 10 10", rd_q.size(), wr_q.size());
      end else begin
         for (int i = 0; i < 10; i++) begin
            checks++;
            if (rd_q[i] !== exp_seq[i] || wr_q[i] !== exp_seq[i]) begin
               errors++;
               $display("FAIL addr_seq[%0d]: got rd=%0d wr=%0d expected %0d", i, rd_q[i], wr_q[i], exp_seq[i]);
            end
         end
      end
   endtask

   task automatic test_fall;
      load_ram(32'h0000_0400, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      sweep(-1, 1'b0);
      checks++;
      if (done_cyc !== 29 || ram[0] !== 32'h0 || ram[2] !== 32'h0000_0400 || ram[4] !== 32'h0) begin
         errors++;
         $display("FAIL fall_1: got done=%0d w0=%h w2=%h w4=%h expected 29 0 00000400 0",
                  done_cyc, ram[0], ram[2], ram[4]);
      end
      sweep(-1, 1'b0);
      checks++;
      if (done_cyc !== 29 || ram[0] !== 32'h0 || ram[2] !== 32'h0 || ram[4] !== 32'h0000_0400) begin
         errors++;
         $display("FAIL fall_2: got done=%0d w0=%h w2=%h w4=%h expected 29 0 0 00000400",
                  done_cyc, ram[0], ram[2], ram[4]);
      end
   endtask

   task automatic test_spout;
      load_ram(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      spout_col = 1'b1;
      sweep(-1, 1'b1);
      checks++;
      if (ram[3] !== 32'h0000_5555) begin
         errors++; $display("FAIL spout_word3: got %h expected 00005555", ram[3]);
      end
      checks++;
      if ((ram[0] | ram[1] | ram[2] | ram[4] | ram[5]) !== 32'h0) begin
         errors++; $display("FAIL spout_others: got or=%h expected 0",
                            ram[0] | ram[1] | ram[2] | ram[4] | ram[5]);
      end
      checks++;
      if (spout_first !== 6 || spout_cnt !== 5) begin
         errors++; $display("FAIL spout_window: got first=%0d cnt=%0d expected 6 5", spout_first, spout_cnt);
      end
      spout_col = 1'b0;
   endtask

   task automatic test_start_while_busy;
      int extra;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      exp_frames = 0;
      load_ram(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      sweep(10, 1'b0);
      checks++;
      if (n_done !== 1 || done_cyc !== 29) begin
         errors++; $display("FAIL restart_done: got count %0d cycle %0d expected 1 29", n_done, done_cyc);
      end
      checks++;
      if (post_fc !== 16'(exp_frames)) begin
         errors++; $display("FAIL restart_fc: got %0d expected %0d", post_fc, exp_frames);
      end
      extra = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (busy || mem_rd || mem_wr) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++; $display("FAIL restart_ignored: got %0d active cycles expected 0", extra);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_reset_mid_sweep();
      test_cycle_count();
      test_address_seq();
      test_fall();
      test_spout();
      test_start_while_busy();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sand_sweep.md
Name: sand_sweep

Overview:
- Frame-level sequencer that walks the cell framebuffer one 32-bit word (16 cells × 2 bits) at a time.
- For each word it reads the region word (row r) and the floor word (row r+1) from single-port RAM and presents them to the combinational sand_update stage. It then writes new_region and new_floor back to RAM.
- Sits between the frame timing controller, which issues start, and the framebuffer RAM.
- Drives sand_update's screenbegin/screenend/screenbottom/spout flags from its row/column counters.

Parameters:
- COLS, 40, words per row (640 px / 16).
- ROWS, 480, rows per frame; must be ≥2.
- AW, 15, RAM word-address width; COLS*ROWS ≤ 2^AW.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a frame sweep when idle.
- spout_en  in  1  enable sand spout this frame.
- spout_col  in  $clog2(COLS)  word column receiving the spout.
- busy  out  1  high from first RD_R until DONE inclusive.
- done  out  1  one-cycle pulse at end of sweep.
- frame_count  out  16  completed sweeps, wraps at 16'hFFFF→0.
- mem_addr  out  AW  RAM word address.
- mem_rd  out  1  read strobe; data valid on mem_rdata the following cycle.
- mem_rdata  in  32  RAM read data.
- mem_wr  out  1  write strobe; writes mem_wdata at mem_addr on this edge.
- mem_wdata  out  32  RAM write data.
- region  out  32  to sand_update.region (registered).
- floor  out  32  to sand_update.floor (registered).
- screenbegin  out  1  col==0.
- screenend  out  1  col==COLS-1.
- screenbottom  out  1  row==ROWS-1.
- spout  out  1  row==0 && col==spout_col && spout_en latched at start.
- new_region  in  32  from sand_update.
- new_floor  in  32  from sand_update.

Behaviour:
- Reset (async, reset_n low):
  - State IDLE; row=0, col=0.
  - region, floor, mem_addr and mem_wdata are 0.
  - mem_rd, mem_wr, busy, done, frame_count and all flags are 0.
- Reset asserted mid-sweep aborts immediately with no further RAM access. A partially swept frame is left as-is.
- Addresses: region_addr = row*COLS+col; floor_addr = region_addr+COLS. Computed with AW-bit arithmetic, no wrap expected.
- Sweep order: row 0→ROWS-1, within each row col 0→COLS-1. SAND_AM marking in sand_update prevents double-falling in one sweep.
- FSM:
  - IDLE: busy=0. On start, latch spout_en into spout_en_q, then go to RD_R. start while not IDLE is ignored.
  - RD_R: mem_rd=1, mem_addr=region_addr → RD_F.
  - RD_F: capture mem_rdata into region.
    - If row<ROWS-1: mem_rd=1, mem_addr=floor_addr.
    - Else: no read.
    - → CAP.
  - CAP: floor ← mem_rdata if row<ROWS-1, else 32'h0. → WR_R.
  - WR_R: mem_wr=1, mem_addr=region_addr, mem_wdata=new_region.
    - If bottom row, advance counters (below).
    - Else → WR_F.
  - WR_F: mem_wr=1, mem_addr=floor_addr, mem_wdata=new_floor. Advance counters.
  - Advance:
    - If col<COLS-1: col++.
    - Else col=0, row++.
    - If the word just written was (ROWS-1, COLS-1): → DONE. Otherwise → RD_R.
  - DONE: done=1 for one cycle, frame_count++, row=col=0 → IDLE.
- Flags are decoded from the counters and are stable from CAP through the final write of each word. sand_update is purely combinational, so new_* is valid in WR_R/WR_F.
- The bottom row's floor write is suppressed: screenbottom's all-WALL floor is virtual and never stored.
- mem_rd and mem_wr are never high together. Exactly one of them is high in RD_R, RD_F (non-bottom), WR_R and WR_F; both are low in CAP, IDLE and DONE.
- Timing: a non-bottom word takes 5 cycles and a bottom word 4 cycles. Sweep length = 5*COLS*(ROWS-1) + 4*COLS cycles. done asserts the cycle after the last write.
- Within a single word step, the floor word written equals the word read back as region in the next row's pass. No read-after-write hazard, since the write completes before that read.

Test Plan:
- Reset: hold reset_n=0 mid-sweep (COLS=2, ROWS=3, start pulsed 7 cycles earlier).
  - All outputs 0 and state IDLE within the same cycle.
  - No mem_wr after release.
- Cycle count: COLS=2, ROWS=3, RAM all 0, start at cycle 0.
  - busy high cycles 1–28.
  - Exactly 10 mem_wr pulses.
  - done high cycle 29; frame_count=1.
  - RAM unchanged.
- Fall: COLS=2, ROWS=3, word0=32'h00000400 (SAND cell 5), rest 0. One sweep gives word0=0, word2=32'h00000400, word4=0. A second sweep gives word2=0, word4=32'h00000400.
- Spout: spout_en=1, spout_col=1, RAM all 0, COLS=2, ROWS=3. Result: word3=32'h00005555, all others 0; spout high only during word (0,1).
- Start while busy: second start pulse at cycle 10. Ignored; single done at cycle 29; frame_count=1.
- Address sequence: COLS=2, ROWS=3.
  - mem_addr read order 0,2,1,3,2,4,3,5,4,5.
  - mem_addr write order 0,2,1,3,2,4,3,5,4,5.
  - Bottom row issues no floor read or write.
